// File: rtl/ram_loader.sv
// Programs the 16-byte RAM from an external byte source while the CPU is frozen.
// Each accepted byte is sent as MI, then RI, then an optional RO read-back. A CPU clear pulse is issued on exit.
module ram_loader #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int HOLD_CYC = 2,
    parameter int CLR_CYC  = 3,
    parameter int VERIFY   = 1
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_load_mode,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    input  logic [DATA_W-1:0] i_bus_in,
    output logic [DATA_W-1:0] o_bus_out,
    output logic              o_bus_oe,
    output logic              o_mi,
    output logic              o_ri,
    output logic              o_ro,
    output logic              o_cpu_hold,
    output logic              o_cpu_clr_n,
    output logic              o_busy,
    output logic [ADDR_W:0]   o_byte_count,
    output logic              o_verify_err,
    output logic [ADDR_W-1:0] o_err_addr
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE, ST_HOLD, ST_READY, ST_ADDR, ST_DATA, ST_VERIFY, ST_RELEASE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_bus_out;
    logic                r_bus_oe;
    logic                r_mi;
    logic                r_ri;
    logic                r_ro;
    logic                r_cpu_hold;
    logic                r_cpu_clr_n;
    logic [ADDR_W:0]     r_byte_count;
    logic                r_verify_err;
    logic [ADDR_W-1:0]   r_err_addr;

    always_ff @(posedge i_clk) begin
        if (!i_clr) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_bus_out    <= '0;
            r_bus_oe     <= 1'b0;
            r_mi         <= 1'b0;
            r_ri         <= 1'b0;
            r_ro         <= 1'b0;
            r_cpu_hold   <= 1'b0;
            r_cpu_clr_n  <= 1'b1;
            r_byte_count <= '0;
            r_verify_err <= 1'b0;
            r_err_addr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_load_mode) begin
                        r_state      <= ST_HOLD;
                        r_cnt        <= '0;
                        r_cpu_hold   <= 1'b1;
                        r_byte_count <= '0;
                        r_verify_err <= 1'b0;
                        r_err_addr   <= '0;
                    end
                end
                ST_HOLD: begin
                    // Let any in-flight CPU step drain before touching the bus.
                    if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
                        r_cnt <= '0;
                        if (i_load_mode) begin
                            r_state <= ST_READY;
                        end else begin
                            r_state     <= ST_RELEASE;
                            r_cpu_clr_n <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (i_wr_valid) begin
                        r_state   <= ST_ADDR;
                        r_addr    <= i_wr_addr;
                        r_data    <= i_wr_data;
                        r_bus_oe  <= 1'b1;
                        r_bus_out <= {{(DATA_W-ADDR_W){1'b0}}, i_wr_addr};
                        r_mi      <= 1'b1;
                    end else if (!i_load_mode) begin
                        r_state     <= ST_RELEASE;
                        r_cnt       <= '0;
                        r_cpu_clr_n <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    r_state   <= ST_DATA;
                    r_bus_out <= r_data;
                    r_mi      <= 1'b0;
                    r_ri      <= 1'b1;
                end
                ST_DATA: begin
                    r_ri      <= 1'b0;
                    r_bus_oe  <= 1'b0;
                    r_bus_out <= '0;
                    if (r_byte_count != '1) begin
                        r_byte_count <= r_byte_count + 1'b1;
                    end
                    if (VERIFY != 0) begin
                        r_state <= ST_VERIFY;
                        r_ro    <= 1'b1;
                    end else begin
                        r_state <= ST_READY;
                    end
                end
                ST_VERIFY: begin
                    r_state <= ST_READY;
                    r_ro    <= 1'b0;
                    if (i_bus_in != r_data) begin
                        r_verify_err <= 1'b1;
                        if (!r_verify_err) begin
                            r_err_addr <= r_addr;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == CNT_W'(CLR_CYC - 1)) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_cpu_hold  <= 1'b0;
                        r_cpu_clr_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_wr_ready   = (r_state == ST_READY);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_bus_out    = r_bus_out;
    assign o_bus_oe     = r_bus_oe;
    assign o_mi         = r_mi;
    assign o_ri         = r_ri;
    assign o_ro         = r_ro;
    assign o_cpu_hold   = r_cpu_hold;
    assign o_cpu_clr_n  = r_cpu_clr_n;
    assign o_byte_count = r_byte_count;
    assign o_verify_err = r_verify_err;
    assign o_err_addr   = r_err_addr;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a small RAM model on the strobes.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       clr;
    logic       load_mode;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       mi, ri, ro;
    logic       cpu_hold, cpu_clr_n, busy;
    logic [4:0] byte_count;
    logic       verify_err;
    logic [3:0] err_addr;

    int total = 0;
    int bad   = 0;
    int strobe_viol = 0;

    logic [7:0] mem [16];
    logic [3:0] mar = 4'h0;
    logic       corrupt_en = 1'b0;

    ram_loader dut (
        .i_clk(clk), .i_clr(clr), .i_load_mode(load_mode),
        .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_wr_ready(wr_ready), .i_bus_in(bus_in), .o_bus_out(bus_out),
        .o_bus_oe(bus_oe), .o_mi(mi), .o_ri(ri), .o_ro(ro),
        .o_cpu_hold(cpu_hold), .o_cpu_clr_n(cpu_clr_n), .o_busy(busy),
        .o_byte_count(byte_count), .o_verify_err(verify_err), .o_err_addr(err_addr)
    );

    always #5 clk = ~clk;

    // RAM model: MAR loads on mi, RAM writes on ri, read-back corrupted at 0x7/0x9 when enabled.
    always @(posedge clk) begin
        if (mi) mar <= bus_out[3:0];
        if (ri) mem[mar] <= bus_out;
    end

    always_comb begin
        bus_in = 8'h00;
        if (ro) begin
            bus_in = mem[mar];
            if (corrupt_en && (mar == 4'h7 || mar == 4'h9)) bus_in = mem[mar] ^ 8'h40;
        end
    end

    always @(negedge clk) begin
        if ((32'(mi) + 32'(ri) + 32'(ro)) > 1 || (ro && bus_oe)) strobe_viol = strobe_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!wr_ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(wr_ready), 32'd1);
    endtask

    task automatic stream();
        wr_valid = 1'b1;
        for (int a = 0; a < 16; a++) begin
            wr_addr = 4'(a);
            wr_data = {4'(a), ~4'(a)};
            wait_ready();
            tick();
        end
        wr_valid = 1'b0;
        wait_ready();
    endtask

    initial begin
        int lowc;
        clr = 1'b0; load_mode = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // Reset state with load_mode held high
        tick(); tick(); tick();
        chk("rst_hold", 32'(cpu_hold), 0);
        chk("rst_clr_n", 32'(cpu_clr_n), 1);
        chk("rst_ready", 32'(wr_ready), 0);
        chk("rst_strobes", {bus_oe, mi, ri, ro}, 0);
        chk("rst_bus", 32'(bus_out), 0);
        chk("rst_cnt", 32'(byte_count), 0);
        chk("rst_err", {verify_err, err_addr}, 0);
        chk("rst_busy", 32'(busy), 0);
        clr = 1'b1;
        tick();
        chk("hold_rise", 32'(cpu_hold), 1);
        chk("hold_noready", 32'(wr_ready), 0);
        tick();
        chk("hold_noready2", 32'(wr_ready), 0);
        tick();
        chk("ready_rise", 32'(wr_ready), 1);

        // Single write 0xA5 -> 0x3 with read-back
        wr_valid = 1'b1; wr_addr = 4'h3; wr_data = 8'hA5;
        tick();
        wr_valid = 1'b0;
        chk("w1_addr", {mi, ri, ro, bus_oe}, 4'b1001);
        chk("w1_addr_bus", 32'(bus_out), 32'h03);
        tick();
        chk("w1_data", {mi, ri, ro, bus_oe}, 4'b0101);
        chk("w1_data_bus", 32'(bus_out), 32'hA5);
        tick();
        chk("w1_verify", {mi, ri, ro, bus_oe}, 4'b0010);
        tick();
        chk("w1_ready_again", 32'(wr_ready), 1);
        chk("w1_err", 32'(verify_err), 0);
        chk("w1_cnt", 32'(byte_count), 1);
        chk("w1_mem", 32'(mem[3]), 32'hA5);

        // Reset pulse in the DATA cycle abandons the byte
        wr_valid = 1'b1; wr_addr = 4'h5; wr_data = 8'h5A;
        tick();
        wr_valid = 1'b0;
        tick();
        chk("rd_in_data", 32'(ri), 1);
        clr = 1'b0;
        tick();
        chk("rd_strobes", {bus_oe, mi, ri, ro}, 0);
        chk("rd_hold", 32'(cpu_hold), 0);
        chk("rd_cnt", 32'(byte_count), 0);
        clr = 1'b1;
        tick();
        wait_ready();

        // Full stream with corrupted read-back at 0x7 and 0x9
        corrupt_en = 1'b1;
        stream();
        chk("st_cnt16", 32'(byte_count), 16);
        chk("st_err", 32'(verify_err), 1);
        chk("st_err_addr", 32'(err_addr), 7);
        chk("st_mem_a", 32'(mem[10]), 32'hA5);
        chk("st_mem_f", 32'(mem[15]), 32'hF0);
        stream();
        chk("st_cnt_sat", 32'(byte_count), 31);
        chk("st_err_addr2", 32'(err_addr), 7);
        corrupt_en = 1'b0;

        // load_mode drops in the ADDR cycle
        wr_valid = 1'b1; wr_addr = 4'h2; wr_data = 8'h3C;
        tick();
        wr_valid = 1'b0;
        load_mode = 1'b0;
        chk("ld_addr", 32'(mi), 1);
        tick();
        chk("ld_data", 32'(ri), 1);
        tick();
        chk("ld_verify", 32'(ro), 1);
        tick();
        chk("ld_ready", 32'(wr_ready), 1);
        chk("ld_mem", 32'(mem[2]), 32'h3C);
        tick();
        lowc = 0;
        while (!cpu_clr_n && lowc < 20) begin
            chk("rel_hold", 32'(cpu_hold), 1);
            lowc++;
            tick();
        end
        chk("rel_clr_len", lowc, 3);
        chk("rel_hold_fall", 32'(cpu_hold), 0);
        chk("rel_idle", 32'(busy), 0);

        // wr_valid and load_mode drop together in READY
        load_mode = 1'b1;
        tick();
        wait_ready();
        wr_valid = 1'b1; wr_addr = 4'hB; wr_data = 8'h77; load_mode = 1'b0;
        tick();
        wr_valid = 1'b0;
        chk("ex_accept", 32'(mi), 1);
        tick(); tick(); tick();
        chk("ex_cnt", 32'(byte_count), 1);
        chk("ex_mem", 32'(mem[11]), 32'h77);
        tick();
        chk("ex_release", 32'(cpu_clr_n), 0);

        chk("strobe_rules", strobe_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Programming controller that fills the 16-byte RAM from an external byte source (switch panel or UART front end) while the CPU is frozen.
- Takes ownership of the shared bus and sequences the same MAR-load / RAM-write strobes the microcode uses: MI, then RI, then an optional RO read-back for verification.
- On exit, issues a CPU clear pulse so execution restarts at PC=0.
- Sits beside the microcode ROM; the top level ORs its mi/ri/ro into the control lines and gates the CPU clock with cpu_hold.

Parameters:
- ADDR_W, 4, RAM address width; upper data bits are driven 0 during the address phase.
- DATA_W, 8, bus/data width.
- HOLD_CYC, 2, cycles between raising cpu_hold and first wr_ready (in-flight CPU step drains).
- CLR_CYC, 3, length in cycles of the cpu_clr_n low pulse on exit.
- VERIFY, 1, 1 = read back every byte after writing it; 0 = skip the VERIFY state.

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous, active-low reset.
- load_mode  in  1  level; 1 = enter/stay in programming mode.
- wr_valid  in  1  source has a byte.
- wr_addr  in  ADDR_W  target address.
- wr_data  in  DATA_W  byte to write.
- wr_ready  out  1  loader accepts a byte this cycle.
- bus_in  in  DATA_W  bus value, sampled during VERIFY.
- bus_out  out  DATA_W  value to drive on the bus.
- bus_oe  out  1  tri-state enable for bus_out.
- mi  out  1  MAR load strobe.
- ri  out  1  RAM write strobe.
- ro  out  1  RAM output-enable strobe.
- cpu_hold  out  1  freeze the CPU clock.
- cpu_clr_n  out  1  active-low CPU clear.
- busy  out  1  any state other than IDLE.
- byte_count  out  ADDR_W+1  bytes written this session; saturates at 2^(ADDR_W+1)-1.
- verify_err  out  1  sticky read-back mismatch flag.
- err_addr  out  ADDR_W  address of the first mismatch.

Behaviour:
- Reset (clr=0 at a clk edge):
  - State IDLE.
  - cpu_hold=0, cpu_clr_n=1; wr_ready, bus_oe, mi, ri, ro = 0.
  - bus_out=0, byte_count=0, verify_err=0, err_addr=0.
  - Reset overrides everything, including mid-transaction; the partially written byte is abandoned.
- States: IDLE, HOLD, READY, ADDR, DATA, VERIFY, RELEASE. All outputs are registered or decoded from state; no combinational input-to-output paths except wr_ready, which is decoded from state only.
- IDLE:
  - If load_mode=1: go to HOLD, raise cpu_hold, clear byte_count, verify_err and err_addr.
- HOLD:
  - cpu_hold=1; counts HOLD_CYC cycles, then goes to READY.
  - If load_mode drops during HOLD, go to RELEASE when the count expires.
- READY:
  - wr_ready=1.
  - If wr_valid=1 at the edge: latch wr_addr/wr_data and go to ADDR. This takes priority over exit.
  - Else if load_mode=0: go to RELEASE.
- ADDR (1 cycle): bus_oe=1, bus_out={0,addr}, mi=1.
- DATA (1 cycle):
  - bus_oe=1, bus_out=data, ri=1.
  - byte_count increments, saturating.
  - Next state is VERIFY if VERIFY=1, else READY.
- VERIFY (1 cycle):
  - bus_oe=0, ro=1; bus_in is sampled at the closing edge.
  - On mismatch with the latched data, set verify_err. Capture err_addr only if verify_err was previously 0, so the first error is kept.
  - Next state READY.
- Strobe rules:
  - Only one of mi/ri/ro is high in any cycle.
  - bus_oe is high only in ADDR/DATA.
  - ro and bus_oe are never high together.
- Throughput: one byte per 3 cycles (VERIFY=0) or 4 cycles (VERIFY=1), counting the accept cycle in READY.
- load_mode dropping during ADDR/DATA/VERIFY: the transaction completes; exit is taken from the next READY.
- RELEASE:
  - cpu_hold stays 1; cpu_clr_n=0 for CLR_CYC cycles.
  - Then go to IDLE; cpu_hold and cpu_clr_n return to 0/1 in the same cycle.
- A load_mode re-assertion during RELEASE is ignored until IDLE is reached.
- Rewriting the same address is permitted; each write counts in byte_count.

Test Plan:
- Reset with load_mode=1 held → all outputs at reset values; cpu_hold rises the cycle after clr releases; wr_ready rises HOLD_CYC cycles later.
- VERIFY=1: write addr 0x3, data 0xA5; bench RAM model returns 0xA5 → mi pulse with bus=0x03, then ri pulse with bus=0xA5, then ro pulse; verify_err=0; byte_count=1; wr_ready high again 4 cycles after accept.
- Stream addresses 0x0–0xF, back-to-back wr_valid, with the model returning a corrupted byte at 0x7 and at 0x9 → byte_count=16, verify_err=1, err_addr=0x7; no cycle with two strobes high.
- Drop load_mode in the ADDR cycle of a write → DATA and VERIFY still complete; then cpu_clr_n is low for exactly CLR_CYC cycles; cpu_hold falls with the return to IDLE.
- Pulse clr low during DATA → next cycle all strobes, bus_oe and cpu_hold are 0; byte_count=0.
- Assert wr_valid and deassert load_mode in the same READY cycle → byte is accepted and written before RELEASE.
